// File: rtl/mp4b_pkg.sv
// Shared definitions for the 4-bit program memory fetch slice.
// The optional parity check is enabled with PROG_MEM_PARITY_EN.
package mp4b_pkg;

  localparam int W     = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  localparam logic [W-1:0] NOP = 4'b0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/prog_mem_fetch_if.sv
// Loader port of prog_mem_fetch. A word is transferred on a rising edge where
// ld_valid_i and ld_ready_o are both 1; data/last/par are meaningful only while valid is 1.
interface prog_mem_fetch_if;
  import mp4b_pkg::*;

  logic         ld_valid_i;
  logic [W-1:0] ld_data_i;
  logic         ld_last_i;
  logic         ld_par_i;
  logic         ld_ready_o;

  modport master (
    output ld_valid_i, ld_data_i, ld_last_i, ld_par_i,
    input  ld_ready_o
  );

  modport slave (
    input  ld_valid_i, ld_data_i, ld_last_i, ld_par_i,
    output ld_ready_o
  );

endinterface

// File: rtl/prog_ram.sv
// Program storage: synchronous write, asynchronous read, contents survive reset.
module prog_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_fetch.sv
// Loads a program of up to 16 nibbles, then serves instruction/operand fetches.
// Define PROG_MEM_PARITY_EN to check even parity on every loaded word.
module prog_mem_fetch #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  prog_mem_fetch_if.slave  ld,
  input  logic [3:0]       PC_i,
  input  logic             A_i,
  input  logic             B_i,
  output logic [W-1:0]     DM_o,
  output logic             dm_valid_o,
  output logic [1:0]       state_o,
  output logic             err_o
);
  import mp4b_pkg::*;

  state_e       state_q, state_d;
  logic [3:0]   wr_ptr;
  logic [4:0]   len;
  logic         ld_ready;
  logic         we;
  logic         serve;
  logic         par_ok;
  logic         par_fail;
  logic [3:0]   rd_addr;
  logic         rd_hit;
  logic [W-1:0] rd_data;

`ifdef PROG_MEM_PARITY_EN
  assign par_ok = ~^{ld.ld_data_i, ld.ld_par_i};
`else
  logic unused_par;
  assign unused_par = ld.ld_par_i;
  assign par_ok     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ld_ready = 1'b0;
    we       = 1'b0;
    serve    = 1'b0;
    par_fail = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld.ld_valid_i) begin
          if (!par_ok) begin
            par_fail = 1'b1;
            state_d  = ST_ERR;
          end else begin
            we = 1'b1;
            if (ld.ld_last_i || wr_ptr == 4'd15) state_d = ST_RUN;
          end
        end
      end
      ST_RUN:  serve = A_i | B_i;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_LOAD;
    endcase
  end

  // A has priority; the operand address wraps naturally in 4 bits.
  assign rd_addr = A_i ? PC_i : PC_i + 4'd1;
  assign rd_hit  = {1'b0, rd_addr} < len;

  prog_ram #(.DEPTH(DEPTH), .W(W), .AW(4)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (ld.ld_data_i),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr     <= 4'd0;
      len        <= 5'd0;
      DM_o       <= NOP;
      dm_valid_o <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 4'd1;
        len    <= len + 5'd1;
      end
      if (serve) DM_o <= rd_hit ? rd_data : NOP;
      dm_valid_o <= serve;
    end
  end

`ifdef PROG_MEM_PARITY_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else if (par_fail) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  logic unused_fail;
  assign unused_fail = par_fail;
  assign err_o       = 1'b0;
`endif

  assign ld.ld_ready_o = ld_ready;
  assign state_o       = state_q;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Directed bench for prog_mem_fetch: load, fetch, wrap, priority, reset and parity cases.
module tb_prog_mem_fetch;

  logic       clk;
  logic       rst_i;
  logic [3:0] pc;
  logic       a_s;
  logic       b_s;
  logic [3:0] dm;
  logic       dm_valid;
  logic [1:0] state;
  logic       err;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef PROG_MEM_PARITY_EN
  localparam bit PAR_FLIP = 1'b0;
`else
  localparam bit PAR_FLIP = 1'b1;
`endif

  prog_mem_fetch_if ld_if ();

  prog_mem_fetch dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .ld         (ld_if.slave),
    .PC_i       (pc),
    .A_i        (a_s),
    .B_i        (b_s),
    .DM_o       (dm),
    .dm_valid_o (dm_valid),
    .state_o    (state),
    .err_o      (err)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change #1 after a rising edge, outputs sampled there too
  task automatic load_word(input logic [3:0] d, input logic last, input logic bad);
    ld_if.ld_valid_i = 1'b1;
    ld_if.ld_data_i  = d;
    ld_if.ld_last_i  = last;
    ld_if.ld_par_i   = (^d) ^ bad;
    @(posedge clk); #1;
    ld_if.ld_valid_i = 1'b0;
    ld_if.ld_last_i  = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] p, input logic a, input logic b);
    pc  = p;
    a_s = a;
    b_s = b;
    @(posedge clk); #1;
    a_s = 1'b0;
    b_s = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_i = 1'b0;
    pc = 4'd0; a_s = 1'b0; b_s = 1'b0;
    ld_if.ld_valid_i = 1'b0;
    ld_if.ld_data_i  = 4'd0;
    ld_if.ld_last_i  = 1'b0;
    ld_if.ld_par_i   = 1'b0;

    #2;
    check("rst_state", state, 2'd0);
    check("rst_dm", dm, 4'h0);
    check("rst_dm_valid", dm_valid, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_ready", ld_if.ld_ready_o, 1'b1);
    @(negedge clk); rst_i = 1'b1;

    // three-word program, last on the third
    load_word(4'b0010, 1'b0, PAR_FLIP);
    check("load1_ready", ld_if.ld_ready_o, 1'b1);
    check("load1_state", state, 2'd0);
    load_word(4'b0100, 1'b0, PAR_FLIP);
    check("load2_ready", ld_if.ld_ready_o, 1'b1);
    load_word(4'b0001, 1'b1, PAR_FLIP);
    check("load3_ready", ld_if.ld_ready_o, 1'b0);
    check("load3_state", state, 2'd1);
    check("load3_len", dut.len, 5'd3);
    check("load3_err", err, 1'b0);

    // loader ignored in RUN
    load_word(4'b1111, 1'b0, 1'b0);
    check("run_ign_len", dut.len, 5'd3);
    check("run_ign_state", state, 2'd1);

    // instruction fetch at PC 1
    strobe(4'd1, 1'b1, 1'b0);
    check("a_pc1_dm", dm, 4'b0100);
    check("a_pc1_valid", dm_valid, 1'b1);
    idle();
    check("a_pc1_valid_drop", dm_valid, 1'b0);
    check("a_pc1_hold", dm, 4'b0100);

    // operand fetch at PC 1 reads address 2
    strobe(4'd1, 1'b0, 1'b1);
    check("b_pc1_dm", dm, 4'b0001);
    check("b_pc1_valid", dm_valid, 1'b1);
    // operand at PC 2 reads address 3, beyond len
    strobe(4'd2, 1'b0, 1'b1);
    check("b_pc2_nop", dm, 4'b0000);
    // A beyond len
    strobe(4'd0, 1'b1, 1'b0);
    strobe(4'd5, 1'b1, 1'b0);
    check("a_pc5_nop", dm, 4'b0000);
    // A wins over B
    strobe(4'd0, 1'b1, 1'b1);
    check("ab_pc0_dm", dm, 4'b0010);
    check("ab_pc0_valid", dm_valid, 1'b1);

    // full 16-word program ends load without last
    rst_i = 1'b0; #1; rst_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_word(4'(i) ^ 4'h5, 1'b0, PAR_FLIP);
      if (i == 14) check("full14_state", state, 2'd0);
    end
    check("full_state", state, 2'd1);
    check("full_ready", ld_if.ld_ready_o, 1'b0);
    check("full_len", dut.len, 5'd16);
    strobe(4'd15, 1'b0, 1'b1);
    check("b_wrap_dm", dm, 4'h5);
    strobe(4'd15, 1'b1, 1'b0);
    check("a_pc15_dm", dm, 4'hA);
    check("a_pc15_valid", dm_valid, 1'b1);

    // asynchronous reset with no clock edge
    rst_i = 1'b0; #1;
    check("async_dm", dm, 4'h0);
    check("async_valid", dm_valid, 1'b0);
    check("async_state", state, 2'd0);
    check("async_ready", ld_if.ld_ready_o, 1'b1);
    rst_i = 1'b1;

    // reset between two load beats
    load_word(4'b1111, 1'b0, PAR_FLIP);
    check("midload_ptr", dut.wr_ptr, 4'd1);
    #2; rst_i = 1'b0; #1;
    check("midload_rst_ptr", dut.wr_ptr, 4'd0);
    check("midload_rst_len", dut.len, 5'd0);
    rst_i = 1'b1;
    load_word(4'b1000, 1'b1, PAR_FLIP);
    check("reload_state", state, 2'd1);
    strobe(4'd0, 1'b1, 1'b0);
    check("reload_pc0", dm, 4'b1000);
    strobe(4'd1, 1'b1, 1'b0);
    check("reload_pc1_nop", dm, 4'b0000);

`ifdef PROG_MEM_PARITY_EN
    rst_i = 1'b0; #1; rst_i = 1'b1;
    load_word(4'b0011, 1'b0, 1'b0);
    check("par_ok_state", state, 2'd0);
    check("par_ok_err", err, 1'b0);
    ld_if.ld_valid_i = 1'b1;
    ld_if.ld_data_i  = 4'b0011;
    ld_if.ld_par_i   = 1'b1;
    @(posedge clk); #1;
    ld_if.ld_valid_i = 1'b0;
    check("par_err", err, 1'b1);
    check("par_state", state, 2'd2);
    check("par_ready", ld_if.ld_ready_o, 1'b0);
    check("par_len", dut.len, 5'd1);
    strobe(4'd0, 1'b1, 1'b0);
    check("par_strobe_valid", dm_valid, 1'b0);
    check("par_strobe_dm", dm, 4'b0000);
    idle();
    check("par_sticky", err, 1'b1);
    rst_i = 1'b0; #1;
    check("par_rst_err", err, 1'b0);
    check("par_rst_state", state, 2'd0);
    rst_i = 1'b1;
`else
    check("nopar_err", err, 1'b0);
`endif

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem_fetch.md
PROG_MEM_FETCH -- requirements
Module: prog_mem_fetch

Interface
REQ-001 Parameter DEPTH, 16, number of program nibbles; fixed to 16 so that a 4-bit PC covers it.
REQ-002 Parameter W, 4, nibble width.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 Port ld_valid_i  input  1  loader offers a word.
REQ-006 Port ld_data_i  input  4  loader word.
REQ-007 Port ld_last_i  input  1  offered word is the final program word.
REQ-008 Port ld_par_i  input  1  even-parity bit of ld_data_i; used only with PROG_MEM_PARITY_EN.
REQ-009 Port ld_ready_o  output  1  block accepts a loader word this cycle.
REQ-010 Port PC_i  input  4  program counter from the pc stage.
REQ-011 Port A_i  input  1  instruction-fetch strobe from gcm.
REQ-012 Port B_i  input  1  operand-fetch strobe from gcm.
REQ-013 Port DM_o  output  4  nibble delivered to reg_ins/reg_dat.
REQ-014 Port dm_valid_o  output  1  DM_o updated by the previous edge.
REQ-015 Port state_o  output  2  current state; 0=LOAD, 1=RUN, 2=ERR.
REQ-016 Port err_o  output  1  sticky load-parity error.

Function
REQ-017 Storage SHALL be DEPTH x W registers, plus a 5-bit length counter len (0..16) and a 4-bit write pointer wr_ptr.
REQ-018 State LOAD SHALL drive ld_ready_o=1. A word is accepted when ld_valid_i=1 and ld_ready_o=1. Acceptance writes mem[wr_ptr], increments wr_ptr and increments len.
REQ-019 LOAD SHALL transition to RUN on the edge that accepts a word with ld_last_i=1, or the word at wr_ptr=15 (full). No further word is accepted.
REQ-020 In RUN, ld_ready_o SHALL be 0 and ld_valid_i SHALL be ignored.
REQ-021 In RUN, A_i=1 at an edge SHALL load DM_o with mem[PC_i] if PC_i<len, else 4'b0000.
REQ-022 In RUN, B_i=1 at an edge SHALL load DM_o with mem[(PC_i+1) mod 16] if that address<len, else 4'b0000. The address wraps 15->0.
REQ-023 When A_i and B_i are both 1, A_i SHALL win and B_i is ignored.
REQ-024 dm_valid_o SHALL be 1 for exactly the one cycle following an edge that serviced A_i or B_i; otherwise it is 0.
REQ-025 Without a strobe, DM_o SHALL hold its value.
REQ-026 In LOAD and ERR, strobes SHALL be ignored, DM_o holds, and dm_valid_o=0.
REQ-027 Read latency SHALL be exactly one clock from strobe edge to DM_o; there are no combinational paths from inputs to outputs.

Reset
REQ-028 rst_i=0 SHALL immediately force: state=LOAD, wr_ptr=0, len=0, DM_o=0000, dm_valid_o=0, err_o=0, ld_ready_o=1 (after release).
REQ-029 Memory contents SHALL NOT be cleared by reset. Because len=0, all RUN reads return 0000 until a new program is loaded.
REQ-030 Reset mid-load or mid-run SHALL abandon the operation; the next program loads from address 0.

Configuration
REQ-031 With PROG_MEM_PARITY_EN defined, each accepted word SHALL be checked against ld_par_i (even parity over ld_data_i^ld_par_i).
- On mismatch, the word is not written, err_o is set (sticky), and the state goes to ERR.
- ERR is left only by reset.
REQ-032 Without PROG_MEM_PARITY_EN, ld_par_i SHALL be ignored, err_o is tied 0, and ERR is unreachable.

Structure
REQ-033 A shared package mp4b_pkg SHALL hold the state encoding (LOAD/RUN/ERR), W, DEPTH and the NOP nibble 4'b0000.
REQ-034 The storage array SHALL be a sub-module prog_ram (sync write, async read, no reset); the FSM and read register live in prog_mem_fetch.

Verification
REQ-035 Reset released, load 0010,0100,0001 with last on the third word -> ld_ready_o drops after the third edge, state_o=1, len=3.
REQ-036 RUN, PC_i=1, A_i pulse -> DM_o=0100 and dm_valid_o=1 one cycle later, then dm_valid_o=0.
REQ-037 RUN, PC_i=15, B_i pulse, program of 16 words -> DM_o=mem[0]; with len=3 and PC_i=5, A_i pulse -> DM_o=0000.
REQ-038 A_i and B_i together at PC_i=0 -> DM_o=mem[0], not mem[1].
REQ-039 rst_i asserted between two load beats -> outputs reset asynchronously without waiting for clk; a reload of 1000 reads back 1000 at PC 0, and PC 1 reads 0000.
REQ-040 PROG_MEM_PARITY_EN: word 0011 with ld_par_i=1 -> err_o=1, state_o=2, and strobes are ignored until reset.
